vid_stream_out: RTL and testbench
=================================

# vid_stream_out

Parametrised clocked-video output stage: consumes a packetised pixel stream (valid/ready, sop/eop) and drives raster timing, H/V sync, datavalid and pixel data for the VGA DAC. It is the generalised successor of the fixed 1024x768 VIP clocked-video path. Resolution, porches, sync polarity, bits per colour and channel count are all parameters. It adds frame locking on start-of-packet, underflow detection and framing-error recovery. It sits between the frame-buffer reader and the VGA pins, in the pixel-clock domain.

## Interface
- H_ACTIVE, 1024, active pixels per line
- H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 768, active lines per frame
- V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porch / sync / porch in lines
- H_POL / V_POL, 0 / 0, sync asserted level (0 = active-low)
- BPC, 8, bits per colour channel
- CH, 3, channels per pixel; W = BPC*CH
- clk  in  1  pixel clock (clk_65 at default timing)
- reset  in  1  synchronous, active-high
- in_data  in  W  pixel, channel 0 in LSBs
- in_valid / in_sop / in_eop  in  1 each  stream qualifiers
- in_ready  out  1  beat accepted when in_valid && in_ready
- vid_data  out  W  pixel, 0 outside active region
- vid_datavalid  out  1  high in active region
- vid_h_sync / vid_v_sync  out  1  syncs at H_POL / V_POL
- vid_h / vid_v  out  16  counter values aligned with vid_data
- underflow / frame_err  out  1  sticky error flags
- err_clr  in  1  clears both flags

## Operation
- Counters: h 0..HT-1 (HT = H_ACTIVE+H_FP+H_SYNC+H_BP), v 0..VT-1 (VT analogous). h wraps to 0 and increments v; v wraps to 0 after VT-1. Counters free-run independently of the stream.
- Active = h<H_ACTIVE && v<V_ACTIVE. Hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vsync is the same on v.
- SEEK: in_ready=1. Non-sop beats are discarded. A sop beat is captured into the hold register -> ARMED.
- ARMED: in_ready=0. At (h,v)=(0,0) the held pixel is emitted -> RUN.
- RUN: in_ready=1 only for active positions other than (0,0).
  - Active position with in_valid=0: underflow set, black pixel emitted -> SEEK. The rest of the frame is black with datavalid still high.
  - sop at an active position other than (0,0): frame_err set, beat captured -> ARMED.
  - eop on a beat other than the last active pixel, or the last active pixel without eop: frame_err set -> SEEK.
- Flags are set on the error cycle. err_clr clears them. If err_clr and a new error coincide, set wins.
- Syncs and datavalid are produced regardless of state. Only pixel content depends on the stream.

## Timing
- One-cycle registered latency: the beat accepted, or the hold pixel emitted, at counter position (h,v) appears on vid_data with vid_h=h, vid_v=v, its syncs and datavalid on the next edge.
- in_ready is a function of registered state and counters only, with no combinational path from in_*.
- Reset values: h=v=0, state SEEK, in_ready=0 during reset, vid_data=0, vid_datavalid=0, syncs at the inactive level (~POL), vid_h=vid_v=0, flags=0. Reset mid-frame takes effect at the next edge and drops any held beat.
- Wrap: after (HT-1,VT-1) comes (0,0) with no gap cycle.

## Structure
- Package vid_pkg holds the state enum {SEEK, ARMED, RUN}, default 1024x768@60 timing constants, and BPC/CH defaults.
- Sub-module vid_timing_gen holds the h/v counters, active/sync decode and last-pixel flag, parametrised identically. The top level holds the stream FSM, hold register and output registers.

## Test plan
Small parameters: H 8/2/3/3 (HT=16), V 4/1/2/1 (VT=8), H_POL=0, V_POL=1.
- Reset for 3 clocks -> vid_h_sync=1, vid_v_sync=0, datavalid=0, in_ready=0. After release, hsync low at h=10..12 and vsync high at v=5..6, with period 16 and 128 clocks.
- Always-valid stream of 32-pixel frames, value = pixel index, sop/eop correct -> vid_data walks 0..31 across active positions, datavalid high for exactly 32 clocks per frame, flags stay 0.
- in_valid dropped at pixel 5 of frame 2 -> underflow=1, rest of frame black. Next sop locks at the following (0,0) with pixel 0 correct.
- sop injected at pixel 12 -> frame_err=1, in_ready low until (0,0), then the injected beat appears as pixel 0.
- eop on pixel 30 -> frame_err=1, state SEEK, lock regained on the next sop.
- err_clr asserted in the same cycle as a new underflow -> underflow remains 1. err_clr alone -> both flags 0 on the next edge.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and default 1024x768@60 timing for the clocked-video output path.
package vid_pkg;
   typedef enum logic [1:0] {SEEK, ARMED, RUN} vid_state_e;

   localparam int CNT_W        = 16;
   localparam int DEF_H_ACTIVE = 1024;
   localparam int DEF_H_FP     = 24;
   localparam int DEF_H_SYNC   = 136;
   localparam int DEF_H_BP     = 160;
   localparam int DEF_V_ACTIVE = 768;
   localparam int DEF_V_FP     = 3;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 29;
   localparam int DEF_BPC      = 8;
   localparam int DEF_CH       = 3;
endpackage

// File: rtl/vid_stream_out_if.sv
// Pixel stream (frame-buffer reader side) and clocked-video (DAC side) bundles.
interface vid_stream_if #(parameter int W = 24);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_sop;
   logic         in_eop;
   logic         in_ready;

   modport master (output in_data, in_valid, in_sop, in_eop, input in_ready);
   modport slave  (input in_data, in_valid, in_sop, in_eop, output in_ready);
endinterface

interface vid_out_if import vid_pkg::*; #(parameter int W = 24);
   logic [W-1:0]     vid_data;
   logic             vid_datavalid;
   logic             vid_h_sync;
   logic             vid_v_sync;
   logic [CNT_W-1:0] vid_h;
   logic [CNT_W-1:0] vid_v;

   modport master (output vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v);
   modport slave  (input vid_data, vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v);
endinterface

// File: rtl/vid_stream_out_timing_gen.sv
// Free-running raster counters with active, sync-window, origin and last-active-pixel decode.
module vid_timing_gen import vid_pkg::*; #(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_o,
   output logic [CNT_W-1:0] v_o,
   output logic             active_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             origin_o,
   output logic             last_o
);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_o      = h_q;
   assign v_o      = v_q;
   assign active_o = (h_q < HA) && (v_q < VA);
   assign hsync_o  = (h_q >= HS_BEG) && (h_q < HS_END);
   assign vsync_o  = (v_q >= VS_BEG) && (v_q < VS_END);
   assign origin_o = (h_q == '0) && (v_q == '0);
   assign last_o   = (h_q == HA - 1'b1) && (v_q == VA - 1'b1);
endmodule

// File: rtl/vid_stream_out.sv
// Clocked-video output stage: locks a sop/eop pixel stream onto free-running raster
// timing and drives syncs, datavalid and pixel data through one register stage.
module vid_stream_out import vid_pkg::*; #(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int BPC      = DEF_BPC,
   parameter int CH       = DEF_CH
) (
   input  logic        clk,
   input  logic        reset,
   vid_stream_if.slave st,
   vid_out_if.master   vo,
   input  logic        err_clr,
   output logic        underflow,
   output logic        frame_err
);
   localparam int W = BPC * CH;

   vid_state_e       state_q, state_d;
   logic [W-1:0]     hold_q, hold_d, pix_d, data_q, data_d;
   logic [CNT_W-1:0] h, v, vh_q, vv_q;
   logic             active, hsync, vsync, origin, last;
   logic             dv_q, hs_q, vs_q, uf_q, uf_d, fe_q, fe_d;
   logic             uf_set, fe_set, rdy;

   vid_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .reset(reset), .h_o(h), .v_o(v), .active_o(active),
      .hsync_o(hsync), .vsync_o(vsync), .origin_o(origin), .last_o(last)
   );

   // Origin (0,0) is never a stream slot in RUN: pixel 0 always comes from the hold register.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pix_d   = '0;
      uf_set  = 1'b0;
      fe_set  = 1'b0;
      rdy     = 1'b0;
      case (state_q)
         SEEK: begin
            rdy = 1'b1;
            if (st.in_valid && st.in_sop) begin
               hold_d  = st.in_data;
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (origin) begin
               pix_d   = hold_q;
               state_d = RUN;
            end
         end
         RUN: begin
            if (active && !origin) begin
               rdy = 1'b1;
               if (!st.in_valid) begin
                  uf_set  = 1'b1;
                  state_d = SEEK;
               end else if (st.in_sop) begin
                  fe_set  = 1'b1;
                  hold_d  = st.in_data;
                  state_d = ARMED;
               end else begin
                  pix_d  = st.in_data;
                  fe_set = (st.in_eop != last);
                  if (st.in_eop || last) state_d = SEEK;
               end
            end
         end
         default: state_d = SEEK;
      endcase
      if (reset) rdy = 1'b0;
   end

   assign uf_d   = uf_set | (uf_q & ~err_clr);
   assign fe_d   = fe_set | (fe_q & ~err_clr);
   assign data_d = active ? pix_d : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEEK;
         hold_q  <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         hs_q    <= ~H_POL;
         vs_q    <= ~V_POL;
         vh_q    <= '0;
         vv_q    <= '0;
         uf_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         dv_q    <= active;
         hs_q    <= hsync ? H_POL : ~H_POL;
         vs_q    <= vsync ? V_POL : ~V_POL;
         vh_q    <= h;
         vv_q    <= v;
         uf_q    <= uf_d;
         fe_q    <= fe_d;
      end
   end

   assign st.in_ready      = rdy;
   assign vo.vid_data      = data_q;
   assign vo.vid_datavalid = dv_q;
   assign vo.vid_h_sync    = hs_q;
   assign vo.vid_v_sync    = vs_q;
   assign vo.vid_h         = vh_q;
   assign vo.vid_v         = vv_q;
   assign underflow        = uf_q;
   assign frame_err        = fe_q;
endmodule

// File: tb/tb_vid_stream_out.sv
// Scoreboard bench for vid_stream_out on a 16x8 raster with an 8x4 active window.
`timescale 1ns/1ps
module tb_vid_stream_out;
   localparam int W = 24;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic err_clr = 1'b0;
   logic underflow, frame_err;

   vid_stream_if #(.W(W)) st_if ();
   vid_out_if    #(.W(W)) vo_if ();

   vid_stream_out #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b1), .BPC(8), .CH(3)
   ) dut (
      .clk(clk), .reset(reset), .st(st_if), .vo(vo_if),
      .err_clr(err_clr), .underflow(underflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int             n_chk = 0;
   int             n_pass = 0;
   logic [W-1:0]   exp_q[$];
   bit             released = 1'b0;
   bit             done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] pix(input int tag, input int idx);
      return W'((tag << 8) | idx);
   endfunction

   // Expected content of one 32-pixel frame: the first n_good pixels of packet 'tag', then black.
   task automatic push_frame(input int tag, input int n_good);
      for (int i = 0; i < 32; i++) exp_q.push_back((i < n_good) ? pix(tag, i) : '0);
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input logic [W-1:0] d, input logic s, input logic e);
      int t;
      st_if.in_data  = d;
      st_if.in_valid = 1'b1;
      st_if.in_sop   = s;
      st_if.in_eop   = e;
      t = 0;
      while (!st_if.in_ready && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      if (!st_if.in_ready) begin
         n_chk++;
         $display("FAIL accept: beat %0h still not ready after %0d cycles", d, t);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_range(input int tag, input int lo, input int hi, input int eop_at);
      for (int i = lo; i <= hi; i++) send(pix(tag, i), (i == 0), (i == eop_at));
   endtask

   task automatic drop(input logic clr);
      st_if.in_valid = 1'b0;
      err_clr = clr;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic clear_flags();
      st_if.in_valid = 1'b0;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("clr_underflow", 64'(underflow), 64'd0);
      check("clr_frame_err", 64'(frame_err), 64'd0);
   endtask

   // Monitor: raster position from a cycle count, pixel content from the scoreboard.
   initial begin : monitor
      int k, h, v;
      logic [34:0] exp_t;
      k = 0;
      wait (released);
      while (!done) begin
         @(negedge clk);
         if (!done) begin
            h = k % 16;
            v = (k / 16) % 8;
            exp_t = {16'(h), 16'(v), !(h >= 10 && h <= 12), (v >= 5 && v <= 6), (h < 8 && v < 4)};
            check("timing h/v/hs/vs/dv",
                  64'({vo_if.vid_h, vo_if.vid_v, vo_if.vid_h_sync, vo_if.vid_v_sync, vo_if.vid_datavalid}),
                  64'(exp_t));
            if (vo_if.vid_datavalid) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL pixel: got %0h at (%0d,%0d) with nothing expected", vo_if.vid_data, h, v);
               end else begin
                  check("pixel", 64'(vo_if.vid_data), 64'(exp_q.pop_front()));
               end
            end else begin
               check("blank", 64'(vo_if.vid_data), 64'd0);
            end
            k++;
         end
      end
   end

   initial begin : stimulus
      st_if.in_data  = '0;
      st_if.in_valid = 1'b0;
      st_if.in_sop   = 1'b0;
      st_if.in_eop   = 1'b0;
      push_frame(0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hsync", 64'(vo_if.vid_h_sync), 64'd1);
      check("rst_vsync", 64'(vo_if.vid_v_sync), 64'd0);
      check("rst_datavalid", 64'(vo_if.vid_datavalid), 64'd0);
      check("rst_ready", 64'(st_if.in_ready), 64'd0);
      check("rst_data", 64'(vo_if.vid_data), 64'd0);
      check("rst_hv", 64'({vo_if.vid_h, vo_if.vid_v}), 64'd0);
      check("rst_flags", 64'({underflow, frame_err}), 64'd0);
      reset = 1'b0;
      released = 1'b1;
      @(posedge clk); #1;

      push_frame(1, 32);
      send_range(1, 0, 31, 31);
      check("f1_flags", 64'({underflow, frame_err}), 64'd0);

      push_frame(2, 5);
      send_range(2, 0, 4, -1);
      drop(1'b0);
      check("uf_set", 64'(underflow), 64'd1);
      check("uf_frame_err", 64'(frame_err), 64'd0);
      send_range(2, 5, 31, 31);
      clear_flags();

      push_frame(3, 12);
      send_range(3, 0, 11, -1);
      push_frame(4, 32);
      send(pix(4, 0), 1'b1, 1'b0);
      check("inj_frame_err", 64'(frame_err), 64'd1);
      check("inj_ready_low", 64'(st_if.in_ready), 64'd0);
      send_range(4, 1, 31, 31);
      clear_flags();

      push_frame(5, 31);
      send_range(5, 0, 29, -1);
      send(pix(5, 30), 1'b0, 1'b1);
      check("eop_frame_err", 64'(frame_err), 64'd1);
      check("eop_underflow", 64'(underflow), 64'd0);

      push_frame(6, 7);
      send_range(6, 0, 6, -1);
      drop(1'b1);
      check("coinc_underflow", 64'(underflow), 64'd1);
      check("coinc_frame_err", 64'(frame_err), 64'd0);
      send_range(6, 7, 31, 31);
      clear_flags();

      push_frame(7, 32);
      send_range(7, 0, 31, 31);
      for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
         @(negedge clk); #1;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d expected pixels never shown", exp_q.size());
      end
      check("end_flags", 64'({underflow, frame_err}), 64'd0);
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
